// File: rtl/vedic_4bit_pipe.sv
// Pipelined 4x4 unsigned Urdhva-Tiryagbhyam multiplier: four 2x2 vedic tiles feed a
// registered partial-product stage, then a shift-add combine stage with optional output register.

module vedic_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] q
);
    logic c1;

    // Vertical and crosswise products; the cross terms can carry into the top bit.
    always_comb begin
        q[0] = a[0] & b[0];
        q[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        c1   = (a[1] & b[0]) & (a[0] & b[1]);
        q[2] = (a[1] & b[1]) ^ c1;
        q[3] = (a[1] & b[1]) & c1;
    end
endmodule

module vedic_4bit_pipe #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] p
);
    logic [3:0] t0, t1, t2, t3;
    logic [3:0] q0_q, q1_q, q2_q, q3_q;
    logic [3:0] q0_d, q1_d, q2_d, q3_d;
    logic       v1_q, v1_d;
    logic       s1_ready, s2_ready;
    logic [4:0] mid;
    logic [7:0] sum;

    vedic_2bit u_tile0 (.a(a[1:0]), .b(b[1:0]), .q(t0));
    vedic_2bit u_tile1 (.a(a[3:2]), .b(b[1:0]), .q(t1));
    vedic_2bit u_tile2 (.a(a[1:0]), .b(b[3:2]), .q(t2));
    vedic_2bit u_tile3 (.a(a[3:2]), .b(b[3:2]), .q(t3));

    assign s1_ready = !v1_q | s2_ready;
    assign in_ready = s1_ready;

    always_comb begin
        v1_d = v1_q;
        q0_d = q0_q;
        q1_d = q1_q;
        q2_d = q2_q;
        q3_d = q3_q;
        if (s1_ready) begin
            v1_d = in_valid;
            if (in_valid) begin
                q0_d = t0;
                q1_d = t1;
                q2_d = t2;
                q3_d = t3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            q0_q <= 4'd0;
            q1_q <= 4'd0;
            q2_q <= 4'd0;
            q3_q <= 4'd0;
        end else begin
            v1_q <= v1_d;
            q0_q <= q0_d;
            q1_q <= q1_d;
            q2_q <= q2_d;
            q3_q <= q3_d;
        end
    end

    // Both cross tiles share weight 4, so they are summed first in 5 bits.
    always_comb begin
        mid = {1'b0, q1_q} + {1'b0, q2_q};
        sum = {4'd0, q0_q} + {1'b0, mid, 2'b00} + {q3_q, 4'd0};
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic       v2_q, v2_d;
            logic [7:0] p_q, p_d;

            always_comb begin
                v2_d = v2_q;
                p_d  = p_q;
                if (s2_ready) begin
                    v2_d = v1_q;
                    if (v1_q) begin
                        p_d = sum;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v2_q <= 1'b0;
                    p_q  <= 8'd0;
                end else begin
                    v2_q <= v2_d;
                    p_q  <= p_d;
                end
            end

            assign s2_ready  = !v2_q | out_ready;
            assign out_valid = v2_q;
            assign p         = p_q;
        end else begin : g_out_comb
            assign s2_ready  = out_ready;
            assign out_valid = v1_q;
            assign p         = sum;
        end
    endgenerate
endmodule

// File: tb/tb_vedic_4bit_pipe.sv
// Directed and randomized bench for vedic_4bit_pipe; drives one instance of each OUT_REG
// setting in turn and checks every product against a queue of a*b computed by the bench.

module tb_vedic_4bit_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid_s  [2];
    logic       in_ready_s  [2];
    logic [3:0] a_s         [2];
    logic [3:0] b_s         [2];
    logic       out_valid_s [2];
    logic       out_ready_s [2];
    logic [7:0] p_s         [2];

    int         total = 0;
    int         bad = 0;
    int         mode = 1;
    int         cyc = 0;
    int         emitted = 0;
    int         last_emit_cyc = -10;
    int         streak = 0;
    int         last_p = 0;
    bit         held = 1'b0;
    logic [7:0] held_p = 8'd0;
    int         exp_q[$];

    vedic_4bit_pipe #(.OUT_REG(1'b0)) dut_comb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0]), .b(b_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .p(p_s[0])
    );

    vedic_4bit_pipe #(.OUT_REG(1'b1)) dut_reg (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1]), .b(b_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .p(p_s[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_output(input string tag, input int obs, input int exp);
        total = total + 1;
        if (obs != exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0d expected %0d (mode OUT_REG=%0d, cycle %0d)",
                     tag, obs, exp, mode, cyc);
        end
    endtask

    // Scoreboard: outputs are popped before inputs are pushed, since an input
    // accepted on an edge can never leave on that same edge.
    always @(negedge clk) begin
        int e;
        if (rst) begin
            exp_q.delete();
            held = 1'b0;
            check_output("rst_out_valid", int'(out_valid_s[mode]), 0);
        end else begin
            if (held) begin
                check_output("hold_valid", int'(out_valid_s[mode]), 1);
                check_output("hold_p", int'(p_s[mode]), int'(held_p));
            end
            if (out_valid_s[mode] && out_ready_s[mode]) begin
                if (exp_q.size() == 0) begin
                    check_output("spurious_out_queue", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_output("product", int'(p_s[mode]), e);
                end
                emitted = emitted + 1;
                last_p  = int'(p_s[mode]);
                if (last_emit_cyc == cyc - 1) streak = streak + 1;
                else streak = 1;
                last_emit_cyc = cyc;
            end
            if (in_valid_s[mode] && in_ready_s[mode]) begin
                exp_q.push_back(int'(a_s[mode]) * int'(b_s[mode]));
            end
            held   = out_valid_s[mode] && !out_ready_s[mode];
            held_p = p_s[mode];
        end
    end

    task automatic apply_stimulus(input logic [3:0] av, input logic [3:0] bv, input bit expect_ready);
        int waited;
        bit accepted;
        waited   = 0;
        accepted = 1'b0;
        a_s[mode]        = av;
        b_s[mode]        = bv;
        in_valid_s[mode] = 1'b1;
        while (!accepted) begin
            @(negedge clk);
            if (expect_ready && waited == 0)
                check_output("in_ready_stream", int'(in_ready_s[mode]), 1);
            if (in_ready_s[mode] && !rst) accepted = 1'b1;
            @(posedge clk);
            #1;
            waited = waited + 1;
            if (!accepted && waited > 300) begin
                check_output("accept_timeout", waited, 0);
                accepted = 1'b1;
            end
        end
        in_valid_s[mode] = 1'b0;
        a_s[mode]        = 4'($urandom_range(0, 15));
        b_s[mode]        = 4'($urandom_range(0, 15));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            #1;
            w = w + 1;
        end
        check_output("drain_queue_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_suite(input int m);
        int  lat;
        bit  rand_run;
        mode = m;
        out_ready_s[m] = 1'b1;

        // Single max-value pair and its latency.
        a_s[m] = 4'd15;
        b_s[m] = 4'd15;
        in_valid_s[m] = 1'b1;
        @(negedge clk);
        check_output("t1_in_ready", int'(in_ready_s[m]), 1);
        @(posedge clk);
        #1;
        in_valid_s[m] = 1'b0;
        lat = 1;
        while (!out_valid_s[m] && lat < 10) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        check_output("t1_latency", lat, (m == 1) ? 2 : 1);
        check_output("t1_p", int'(p_s[m]), 225);
        @(posedge clk);
        #1;
        check_output("t1_one_cycle", int'(out_valid_s[m]), 0);
        drain();

        // All 256 pairs back to back.
        for (int i = 0; i < 256; i++) apply_stimulus(4'(i >> 4), 4'(i & 15), 1'b1);
        drain();
        check_output("t2_no_bubble_streak", streak, 256);

        // Stall with a full pipe, then release.
        out_ready_s[m] = 1'b0;
        fork
            begin
                apply_stimulus(4'd9, 4'd6, 1'b0);
                apply_stimulus(4'd3, 4'd10, 1'b0);
                apply_stimulus(4'd0, 4'd13, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                check_output("t3_p_held", int'(p_s[m]), 54);
                check_output("t3_out_valid", int'(out_valid_s[m]), 1);
                check_output("t3_in_ready_full", int'(in_ready_s[m]), 0);
                @(posedge clk);
                #1;
                out_ready_s[m] = 1'b1;
            end
        join
        drain();
        check_output("t3_last_product", last_p, 0);

        // Random valid/ready traffic.
        rand_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 4000; i++) begin
                    while ($urandom_range(0, 1) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    apply_stimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
                end
                rand_run = 1'b0;
            end
            begin
                while (rand_run) begin
                    @(posedge clk);
                    #1;
                    out_ready_s[m] = ($urandom_range(0, 99) < 30);
                end
            end
        join
        out_ready_s[m] = 1'b1;
        drain();
    endtask

    initial begin
        int base;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid_s[k]  = 1'b0;
            out_ready_s[k] = 1'b1;
            a_s[k]         = 4'd0;
            b_s[k]         = 4'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_output("reset_out_valid", int'(out_valid_s[k]), 0);
            check_output("reset_p", int'(p_s[k]), 0);
            check_output("reset_in_ready", int'(in_ready_s[k]), 1);
        end

        run_suite(1);

        // Reset while two products are in flight.
        out_ready_s[1] = 1'b0;
        apply_stimulus(4'd7, 4'd7, 1'b0);
        apply_stimulus(4'd8, 4'd3, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_output("t5_rst_async_out_valid", int'(out_valid_s[1]), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready_s[1] = 1'b1;
        check_output("t5_in_ready_after_rst", int'(in_ready_s[1]), 1);
        base = emitted;
        repeat (5) @(posedge clk);
        #1;
        check_output("t5_no_stale_product", emitted - base, 0);
        apply_stimulus(4'd12, 4'd5, 1'b1);
        drain();
        check_output("t5_p_after_rst", last_p, 60);
        check_output("t5_one_emitted", emitted - base, 1);

        run_suite(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
